// File: rtl/dist_sram_banked_mw_pkg.sv
// rtl/dist_sram_banked_mw_pkg.sv - shared types/helpers; DIST_SRAM_OUT_REG_EN selects the read latency
package dist_sram_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE   = 1'b0,
    CLR_ACTIVE = 1'b1
  } clr_state_t;

`ifdef DIST_SRAM_OUT_REG_EN
  localparam int DIST_SRAM_RD_LAT = 2;
`else
  localparam int DIST_SRAM_RD_LAT = 1;
`endif

  // Per-bit select; callers expand the lane mask to bit granularity.
  function automatic logic lane_merge(input logic old_v, input logic new_v, input logic mask_v);
    return mask_v ? new_v : old_v;
  endfunction

endpackage

// File: rtl/dist_sram_banked_mw_if.sv
// rtl/dist_sram_banked_mw_if.sv - write/read/clear bus of the banked distance SRAM
interface dist_sram_banked_mw_if #(
  parameter int BW         = 1,
  parameter int D          = 256,
  parameter int ADDR_SPACE = 12
);
  logic                  wsb;
  logic [D-1:0]          wmask;
  logic [D*BW-1:0]       wdata;
  logic [ADDR_SPACE-1:0] waddr;
  logic                  rsb;
  logic [ADDR_SPACE-1:0] raddr;
  logic [D*BW-1:0]       rdata;
  logic                  rvalid;
  logic                  clr_req;
  logic                  clr_busy;

  modport master (
    output wsb, wmask, wdata, waddr, rsb, raddr, clr_req,
    input  rdata, rvalid, clr_busy
  );

  modport slave (
    input  wsb, wmask, wdata, waddr, rsb, raddr, clr_req,
    output rdata, rvalid, clr_busy
  );
endinterface

// File: rtl/dist_sram_banked_mw_clr_fsm.sv
// rtl/dist_sram_banked_mw_clr_fsm.sv - clear engine: walks every word once, DEPTH cycles per clear
module dist_sram_clr_fsm
  import dist_sram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr_req,
  output logic [AW-1:0] o_clr_addr,
  output logic          o_clr_we,
  output logic          o_clr_busy
);
  localparam logic [0:0]    S_IDLE   = CLR_IDLE;
  localparam logic [0:0]    S_ACTIVE = CLR_ACTIVE;
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

  logic [0:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic          w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_clr_req) begin
            r_state <= S_ACTIVE;
            r_cnt   <= '0;
          end
        end
        S_ACTIVE: begin
          // Requests arriving here are dropped; the sweep never restarts.
          if (r_cnt == LP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy     = (r_state == S_ACTIVE);
  assign o_clr_busy = w_busy;
  assign o_clr_we   = w_busy;
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/dist_sram_banked_mw.sv
// rtl/dist_sram_banked_mw.sv - banked distance SRAM with lane masks, write-first bypass and clear engine
// Optional DIST_SRAM_OUT_REG_EN adds an output register stage (2-cycle read latency).
module dist_sram_banked_mw
  import dist_sram_pkg::*;
#(
  parameter int BW         = 1,
  parameter int D          = 256,
  parameter int DEPTH      = 4096,
  parameter int ADDR_SPACE = 12
) (
  input logic                  clk,
  input logic                  rst,
  dist_sram_banked_mw_if.slave io_bus
);
  localparam int                  W        = D * BW;
  localparam int                  AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SPACE:0] LP_DEPTH = (ADDR_SPACE + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_rdata;
  logic          r_rvalid;

  logic [AW-1:0] w_clr_addr;
  logic          w_clr_we;
  logic          w_busy;
  logic          w_wr_in;
  logic          w_rd_in;
  logic          w_wr_en;
  logic          w_byp;
  logic [AW-1:0] w_waddr_idx;
  logic [AW-1:0] w_raddr_idx;
  logic [W-1:0]  w_wr_old;
  logic [W-1:0]  w_wr_word;
  logic [W-1:0]  w_rd_word;

  dist_sram_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_clr_req  (io_bus.clr_req),
    .o_clr_addr (w_clr_addr),
    .o_clr_we   (w_clr_we),
    .o_clr_busy (w_busy)
  );

  assign w_wr_in     = ({1'b0, io_bus.waddr} < LP_DEPTH);
  assign w_rd_in     = ({1'b0, io_bus.raddr} < LP_DEPTH);
  assign w_waddr_idx = io_bus.waddr[AW-1:0];
  assign w_raddr_idx = io_bus.raddr[AW-1:0];
  assign w_wr_en     = !io_bus.wsb && w_wr_in && !w_busy;
  assign w_byp       = w_wr_en && (io_bus.waddr == io_bus.raddr);
  assign w_wr_old    = r_mem[w_waddr_idx];

  always_comb begin
    w_wr_word = w_wr_old;
    for (int b = 0; b < W; b++) begin
      w_wr_word[b] = lane_merge(w_wr_old[b], io_bus.wdata[b], io_bus.wmask[b / BW]);
    end
  end

  // Reads during a clear return zero even for words not yet swept.
  always_comb begin
    w_rd_word = '0;
    if (!w_busy && w_rd_in) begin
      w_rd_word = w_byp ? w_wr_word : r_mem[w_raddr_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[w_clr_addr] <= '0;
      end else if (w_wr_en) begin
        r_mem[w_waddr_idx] <= w_wr_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= !io_bus.rsb;
      if (!io_bus.rsb) begin
        r_rdata <= w_rd_word;
      end
    end
  end

`ifdef DIST_SRAM_OUT_REG_EN
  logic [W-1:0] r_rdata_q;
  logic         r_rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_q  <= '0;
      r_rvalid_q <= 1'b0;
    end else begin
      r_rdata_q  <= r_rdata;
      r_rvalid_q <= r_rvalid;
    end
  end

  assign io_bus.rdata  = r_rdata_q;
  assign io_bus.rvalid = r_rvalid_q;
`else
  assign io_bus.rdata  = r_rdata;
  assign io_bus.rvalid = r_rvalid;
`endif

  assign io_bus.clr_busy = w_busy;

endmodule

// File: tb/tb_dist_sram_banked_mw.sv
// tb/tb_dist_sram_banked_mw.sv - directed self-checking bench for dist_sram_banked_mw
module tb_dist_sram_banked_mw;
  localparam int BW      = 2;
  localparam int D       = 8;
  localparam int DEPTH_A = 64;
  localparam int AS_A    = 7;
  localparam int DEPTH_B = 4000;
  localparam int AS_B    = 12;
`ifdef DIST_SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dist_sram_banked_mw_if #(.BW(BW), .D(D), .ADDR_SPACE(AS_A)) bus_a ();
  dist_sram_banked_mw_if #(.BW(BW), .D(D), .ADDR_SPACE(AS_B)) bus_b ();

  dist_sram_banked_mw #(.BW(BW), .D(D), .DEPTH(DEPTH_A), .ADDR_SPACE(AS_A)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_a)
  );

  dist_sram_banked_mw #(.BW(BW), .D(D), .DEPTH(DEPTH_B), .ADDR_SPACE(AS_B)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_a.wsb = 1'b1; bus_a.rsb = 1'b1; bus_a.clr_req = 1'b0;
    bus_a.wmask = '0; bus_a.wdata = '0; bus_a.waddr = '0; bus_a.raddr = '0;
    bus_b.wsb = 1'b1; bus_b.rsb = 1'b1; bus_b.clr_req = 1'b0;
    bus_b.wmask = '0; bus_b.wdata = '0; bus_b.waddr = '0; bus_b.raddr = '0;
  endtask

  task automatic a_write(input logic [6:0] addr, input logic [15:0] data, input logic [7:0] mask);
    bus_a.wsb = 1'b0; bus_a.waddr = addr; bus_a.wdata = data; bus_a.wmask = mask;
    tick();
    bus_a.wsb = 1'b1;
  endtask

  task automatic a_read(input logic [6:0] addr, output logic [15:0] data, output logic vld);
    bus_a.rsb = 1'b0; bus_a.raddr = addr;
    tick();
    bus_a.rsb = 1'b1;
    repeat (LAT - 1) tick();
    data = bus_a.rdata;
    vld  = bus_a.rvalid;
  endtask

  task automatic b_write(input logic [11:0] addr, input logic [15:0] data);
    bus_b.wsb = 1'b0; bus_b.waddr = addr; bus_b.wdata = data; bus_b.wmask = 8'hFF;
    tick();
    bus_b.wsb = 1'b1;
  endtask

  task automatic b_read(input logic [11:0] addr, output logic [15:0] data, output logic vld);
    bus_b.rsb = 1'b0; bus_b.raddr = addr;
    tick();
    bus_b.rsb = 1'b1;
    repeat (LAT - 1) tick();
    data = bus_b.rdata;
    vld  = bus_b.rvalid;
  endtask

  task automatic a_fill(input logic [15:0] data);
    for (int i = 0; i < DEPTH_A; i++) a_write(7'(i), data, 8'hFF);
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus_a.rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata_a got=%h exp=0000", bus_a.rdata); end
    total++; if (bus_a.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid_a got=%b exp=0", bus_a.rvalid); end
    total++; if (bus_a.clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b exp=0", bus_a.clr_busy); end
    total++; if (bus_b.rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata_b got=%h exp=0000", bus_b.rdata); end
    total++; if (bus_b.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid_b got=%b exp=0", bus_b.rvalid); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    a_write(7'd5, 16'hFFFF, 8'hFF);
    bus_a.rsb = 1'b0; bus_a.raddr = 7'd5;
    tick();
    bus_a.rsb = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      total++;
      if (bus_a.rvalid !== 1'(k == LAT)) begin
        bad++; $display("FAIL wr_rd_rvalid cyc=%0d got=%b exp=%b", k, bus_a.rvalid, k == LAT);
      end
      if (k >= LAT) begin
        total++;
        if (bus_a.rdata !== 16'hFFFF) begin
          bad++; $display("FAIL wr_rd_rdata cyc=%0d got=%h exp=ffff", k, bus_a.rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    logic [15:0] d;
    logic        v;
    a_write(7'd7, 16'hFFFF, 8'hFF);
    bus_a.wsb = 1'b0; bus_a.waddr = 7'd7; bus_a.wdata = 16'h0; bus_a.wmask = 8'h0F;
    bus_a.rsb = 1'b0; bus_a.raddr = 7'd7;
    tick();
    bus_a.wsb = 1'b1; bus_a.rsb = 1'b1;
    repeat (LAT - 1) tick();
    total++; if (bus_a.rdata !== 16'hFF00) begin bad++; $display("FAIL bypass_rdata got=%h exp=ff00", bus_a.rdata); end
    total++; if (bus_a.rvalid !== 1'b1) begin bad++; $display("FAIL bypass_rvalid got=%b exp=1", bus_a.rvalid); end
    a_read(7'd7, d, v);
    total++; if (d !== 16'hFF00) begin bad++; $display("FAIL bypass_stored got=%h exp=ff00", d); end
    a_write(7'd8, 16'h0000, 8'hFF);
    a_write(7'd8, 16'hFFFF, 8'hA5);
    a_read(7'd8, d, v);
    total++; if (d !== 16'hCC33) begin bad++; $display("FAIL sparse_mask got=%h exp=cc33", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s_d [4];
    logic        s_v [4];
    bus_a.rsb = 1'b0; bus_a.raddr = 7'd5;
    tick();
    s_d[1] = bus_a.rdata; s_v[1] = bus_a.rvalid;
    bus_a.raddr = 7'd7;
    tick();
    s_d[2] = bus_a.rdata; s_v[2] = bus_a.rvalid;
    bus_a.rsb = 1'b1;
    tick();
    s_d[3] = bus_a.rdata; s_v[3] = bus_a.rvalid;
    total++; if (s_d[LAT] !== 16'hFFFF || s_v[LAT] !== 1'b1) begin
      bad++; $display("FAIL b2b_first got=%h/%b exp=ffff/1", s_d[LAT], s_v[LAT]);
    end
    total++; if (s_d[LAT+1] !== 16'hFF00 || s_v[LAT+1] !== 1'b1) begin
      bad++; $display("FAIL b2b_second got=%h/%b exp=ff00/1", s_d[LAT+1], s_v[LAT+1]);
    end
  endtask

  task automatic test_clear();
    logic [15:0] d;
    logic        v;
    int          n;
    a_fill(16'hFFFF);
    bus_a.clr_req = 1'b1;
    tick();
    bus_a.clr_req = 1'b0;
    n = 0;
    while (bus_a.clr_busy === 1'b1 && n < 200) begin
      n++;
      if (n == 5) begin bus_a.rsb = 1'b0; bus_a.raddr = 7'd63; end
      if (n == 5 + LAT) begin
        total++;
        if (bus_a.rdata !== 16'h0 || bus_a.rvalid !== 1'b1) begin
          bad++; $display("FAIL clear_read got=%h/%b exp=0000/1", bus_a.rdata, bus_a.rvalid);
        end
      end
      if (n == 6) bus_a.rsb = 1'b1;
      if (n == 10) begin
        bus_a.wsb = 1'b0; bus_a.waddr = 7'd3; bus_a.wdata = 16'hFFFF; bus_a.wmask = 8'hFF;
      end
      if (n == 11) bus_a.wsb = 1'b1;
      bus_a.clr_req = (n == 20);
      tick();
    end
    bus_a.clr_req = 1'b0;
    total++; if (n != DEPTH_A) begin bad++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", n, DEPTH_A); end
    for (int i = 0; i < DEPTH_A; i++) begin
      a_read(7'(i), d, v);
      total++;
      if (d !== 16'h0) begin bad++; $display("FAIL clear_word%0d got=%h exp=0000", i, d); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [15:0] d;
    logic [15:0] e;
    logic        v;
    a_fill(16'hFFFF);
    bus_a.clr_req = 1'b1;
    tick();
    bus_a.clr_req = 1'b0;
    repeat (10) tick();
    total++; if (bus_a.clr_busy !== 1'b1) begin bad++; $display("FAIL midclr_busy_pre got=%b exp=1", bus_a.clr_busy); end
    rst = 1'b1;
    bus_a.wsb = 1'b0; bus_a.waddr = 7'd40; bus_a.wdata = 16'h0; bus_a.wmask = 8'hFF;
    bus_a.rsb = 1'b0; bus_a.raddr = 7'd0;
    tick();
    rst = 1'b0; bus_a.wsb = 1'b1; bus_a.rsb = 1'b1;
    total++; if (bus_a.clr_busy !== 1'b0) begin bad++; $display("FAIL midclr_busy_post got=%b exp=0", bus_a.clr_busy); end
    total++; if (bus_a.rvalid !== 1'b0 || bus_a.rdata !== 16'h0) begin
      bad++; $display("FAIL midclr_rd_reset got=%h/%b exp=0000/0", bus_a.rdata, bus_a.rvalid);
    end
    for (int i = 0; i < DEPTH_A; i++) begin
      a_read(7'(i), d, v);
      e = (i < 10) ? 16'h0000 : 16'hFFFF;
      total++;
      if (d !== e) begin bad++; $display("FAIL midclr_word%0d got=%h exp=%h", i, d, e); end
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] d;
    logic        v;
    a_write(7'd64, 16'hFFFF, 8'hFF);
    a_read(7'd0, d, v);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL oor_alias0 got=%h exp=0000", d); end
    a_write(7'd74, 16'h0000, 8'hFF);
    a_read(7'd10, d, v);
    total++; if (d !== 16'hFFFF) begin bad++; $display("FAIL oor_alias10 got=%h exp=ffff", d); end
    a_read(7'd100, d, v);
    total++; if (d !== 16'h0000 || v !== 1'b1) begin bad++; $display("FAIL oor_read_a got=%h/%b exp=0000/1", d, v); end
    b_write(12'd0, 16'h1234);
    b_write(12'd3999, 16'hABCD);
    b_read(12'd0, d, v);
    total++; if (d !== 16'h1234 || v !== 1'b1) begin bad++; $display("FAIL b_word0 got=%h/%b exp=1234/1", d, v); end
    b_read(12'd4000, d, v);
    total++; if (d !== 16'h0000 || v !== 1'b1) begin bad++; $display("FAIL b_oor_read got=%h/%b exp=0000/1", d, v); end
    b_write(12'd4000, 16'hFFFF);
    b_write(12'd4095, 16'hFFFF);
    b_read(12'd0, d, v);
    total++; if (d !== 16'h1234) begin bad++; $display("FAIL b_word0_kept got=%h exp=1234", d); end
    b_read(12'd3999, d, v);
    total++; if (d !== 16'hABCD) begin bad++; $display("FAIL b_last_word got=%h exp=abcd", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dist_sram_banked_mw.md
Name: dist_sram_banked_mw

Overview:
Parametrised successor to the single-port distance bank.
- Holds DEPTH words of D lanes x BW bits.
- Adds per-lane write masking, a write-first read bypass, a read-valid flag, and a hardware clear engine.
- Sits between the distance-compute array (writer) and the graph-update logic (reader). The clear engine wipes a bank between batches.

Parameters:
BW, 1, bits per lane
D, 256, lanes per word
DEPTH, 4096, words in the bank; need not be a power of two
ADDR_SPACE, 12, address width; must satisfy 2**ADDR_SPACE >= DEPTH

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
wsb  in  1  write strobe, active-low
wmask  in  D  per-lane write enable, 1 = lane written
wdata  in  D*BW  write data; lane i = wdata[i*BW +: BW]
waddr  in  ADDR_SPACE  write address
rsb  in  1  read strobe, active-low
raddr  in  ADDR_SPACE  read address
rdata  out  D*BW  read data
rvalid  out  1  rdata holds the result of a read
clr_req  in  1  one-cycle pulse; starts a full-bank clear
clr_busy  out  1  clear engine active

Behaviour:
Reset values:
- rdata = 0, rvalid = 0, clr_busy = 0.
- FSM = IDLE, clear counter = 0.
- Memory array is not reset.

Write:
- When wsb == 0, waddr < DEPTH and FSM = IDLE, lanes with wmask[i] = 1 update at posedge; other lanes are kept.
- waddr >= DEPTH: write dropped.

Read:
- When rsb == 0, rdata is registered at posedge: one-cycle latency. rvalid = 1 in the following cycle, otherwise 0.
- raddr >= DEPTH: rdata = 0, rvalid = 1.
- rsb == 1: rdata holds its previous value, rvalid = 0.

Same-cycle read and write to the same address (write-first):
- rdata = masked merge of old word and wdata, i.e. the post-write contents.

FSM states:
- IDLE: clr_req -> CLEAR, counter = 0, clr_busy = 1.
- CLEAR: writes zero to word[counter] each cycle and increments the counter. At counter == DEPTH-1 that word is cleared and the FSM goes to IDLE next cycle. Clear takes exactly DEPTH cycles with clr_busy high.
- In CLEAR, external writes are ignored (not queued).
- In CLEAR, reads are still accepted, return 0 and assert rvalid.
- clr_req while in CLEAR is ignored; no restart.

Reset mid-clear:
- Aborts immediately: FSM = IDLE, clr_busy = 0.
- Words already cleared stay 0; the rest are unchanged.

Simultaneous rst with any strobe: rst wins, and no write or clear occurs that cycle.

Optional Feature:
DIST_SRAM_OUT_REG_EN
- Defined: adds one output pipeline register after the read register.
  - rdata and rvalid arrive 2 cycles after the rsb strobe.
  - The pipeline register resets to 0 and rvalid resets to 0.
  - The bypass compares against the write in the strobe cycle only.
- Undefined: 1-cycle latency as above.

Decomposition:
- Package dist_sram_pkg:
  - clr_state_t enum {CLR_IDLE, CLR_ACTIVE}.
  - Function lane_merge(old, new, mask) for the masked write and bypass merge.
  - Constant DIST_SRAM_RD_LAT (1, or 2 when DIST_SRAM_OUT_REG_EN is defined).
- Sub-module dist_sram_clr_fsm: owns the FSM and counter. Outputs clear address, clear write enable and clr_busy to the array wrapper.

Test Plan:
1. Write wdata lanes all 1, full wmask, addr 5; next cycle read addr 5 -> rdata all 1 one cycle later, rvalid = 1 for exactly one cycle.
2. Word 7 = all 1; write lanes 0-3 = 0 with wmask = 0xF and a same-cycle read of addr 7 -> rdata lanes 0-3 = 0, lanes 4..D-1 = 1 (bypass and merge).
3. Fill words 0..DEPTH-1 = all 1; pulse clr_req -> clr_busy high exactly DEPTH cycles; a write to addr 3 during clear is dropped; afterwards every word reads 0.
4. Assert rst at clear cycle 10 with DEPTH = 64 -> clr_busy = 0 next cycle; words 0-9 = 0, words 10-63 = all 1.
5. Read raddr = DEPTH with DEPTH = 4000 -> rdata = 0, rvalid = 1; write to waddr = DEPTH then read word 0 -> word 0 unchanged.
6. Rebuild with DIST_SRAM_OUT_REG_EN; rerun scenario 1 -> data and rvalid appear 2 cycles after the strobe.
